// File: rtl/fifo_drain_ctrl_if.sv
// Groups the FIFO read-port and output-stream signals of fifo_drain_ctrl.
// master: the drain controller (drives rd_en/clear and the output stream).
// slave : the FIFO plus downstream consumer (drives read data, flags and ready).
// Ports: fifo_data_i/fifo_empty_i/fifo_count_i/m_ready_i into the controller;
//        fifo_rd_en_o/fifo_clear_o/m_data_o/m_valid_o/m_last_o out of it.
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    fifo_data_i;
  logic                     fifo_empty_i;
  logic [ADDRESS_WIDTH-1:0] fifo_count_i;
  logic                     fifo_rd_en_o;
  logic                     fifo_clear_o;
  logic [DATA_WIDTH-1:0]    m_data_o;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic                     m_last_o;

  modport master (
    input  fifo_data_i, fifo_empty_i, fifo_count_i, m_ready_i,
    output fifo_rd_en_o, fifo_clear_o, m_data_o, m_valid_o, m_last_o
  );

  modport slave (
    output fifo_data_i, fifo_empty_i, fifo_count_i, m_ready_i,
    input  fifo_rd_en_o, fifo_clear_o, m_data_o, m_valid_o, m_last_o
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Purpose: drains a FIFO in bursts into a valid/ready stream, with flush/clear control.
// Latency: read issued in cycle t, word lands in a 2-entry skid buffer at t+1, visible t+2.
// Backpressure: m_ready_i low stalls the stream; reads stop once skid + in-flight reach 2.
// Ports: RClk, PresetFull (async active-high), flush_i, busy_o, bus (fifo_drain_ctrl_if.master).
// Optional: define FIFO_DRAIN_TIMEOUT_EN to force a partial burst after TIMEOUT_CYCLES idle cycles.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CLEAR_CYCLES   = 4
) (
  input  logic                 RClk,
  input  logic                 PresetFull,
  input  logic                 flush_i,
  output logic                 busy_o,
  fifo_drain_ctrl_if.master    bus
);

  if (BURST_LEN < 1 || BURST_LEN > (1 << ADDRESS_WIDTH) - 1) begin : g_bad_burst
    $error("BURST_LEN out of range");
  end
  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_bad_clear
    $error("CLEAR_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, FLUSH} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] dat;
  } skid_t;

  localparam logic [ADDRESS_WIDTH-1:0] BURST_LEN_W = ADDRESS_WIDTH'(BURST_LEN);
  localparam logic [ADDRESS_WIDTH-1:0] ONE_W       = ADDRESS_WIDTH'(1);
  localparam logic [3:0]               CLEAR_LAST  = 4'(CLEAR_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] burst_len_q, issued_q;
  logic                     rd_inflight_q, inflight_last_q;
  skid_t                    skid0_q, skid1_q;
  logic [1:0]               skid_cnt_q;
  logic [3:0]               clear_cnt_q;

  logic                     start_full, start_timeout, start_any;
  logic [ADDRESS_WIDTH-1:0] start_len;
  logic                     rd_en, final_rd, clear_en, busy;
  logic                     push, pop;
  logic [1:0]               occ_after;
  skid_t                    push_ent;

  assign start_full = (state_q == IDLE) && (bus.fifo_count_i >= BURST_LEN_W);
  assign start_any  = start_full || start_timeout;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_tmr_q;
  logic        tmr_run;

  // Timer only advances while a partial burst is sitting in the FIFO.
  assign tmr_run       = (state_q == IDLE) && !bus.fifo_empty_i && (bus.fifo_count_i < BURST_LEN_W);
  assign start_timeout = tmr_run && (idle_tmr_q == TIMEOUT_LAST);
  assign start_len     = (bus.fifo_count_i == '0) ? ONE_W : bus.fifo_count_i;

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      idle_tmr_q <= '0;
    end else if (!tmr_run || start_timeout || flush_i) begin
      idle_tmr_q <= '0;
    end else begin
      idle_tmr_q <= idle_tmr_q + 16'd1;
    end
  end
`else
  assign start_timeout = 1'b0;
  assign start_len     = BURST_LEN_W;
`endif

  // Occupancy the skid buffer will have after this edge; counting this cycle's
  // pop lets reads stream back-to-back while never overfilling the buffer.
  assign pop       = (skid_cnt_q != 2'd0) && bus.m_ready_i;
  assign push      = rd_inflight_q;
  assign occ_after = skid_cnt_q - {1'b0, pop} + {1'b0, rd_inflight_q};
  assign push_ent  = '{last: inflight_last_q, dat: bus.fifo_data_i};

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    final_rd = 1'b0;
    clear_en = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_any) state_d = BURST;
      end
      BURST: begin
        rd_en    = !bus.fifo_empty_i && (issued_q < burst_len_q) && (occ_after < 2'd2) && !flush_i;
        final_rd = rd_en && (issued_q == burst_len_q - ONE_W);
        if (final_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if ((skid_cnt_q == 2'd0) && !rd_inflight_q) state_d = IDLE;
      end
      FLUSH: begin
        clear_en = 1'b1;
        if (clear_cnt_q == CLEAR_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over burst start, timeout and normal completion.
    if (flush_i) state_d = FLUSH;
  end

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      state_q         <= IDLE;
      burst_len_q     <= '0;
      issued_q        <= '0;
      rd_inflight_q   <= 1'b0;
      inflight_last_q <= 1'b0;
      skid0_q         <= '0;
      skid1_q         <= '0;
      skid_cnt_q      <= 2'd0;
      clear_cnt_q     <= 4'd0;
    end else begin
      state_q         <= state_d;
      rd_inflight_q   <= rd_en;
      inflight_last_q <= final_rd;

      if (start_any) begin
        burst_len_q <= start_full ? BURST_LEN_W : start_len;
        issued_q    <= '0;
      end else if (rd_en) begin
        issued_q <= issued_q + ONE_W;
      end

      if (flush_i) begin
        clear_cnt_q <= 4'd0;
      end else if (state_q == FLUSH) begin
        clear_cnt_q <= clear_cnt_q + 4'd1;
      end

      // Flush discards buffered words; the in-flight read is dropped because
      // rd_inflight_q is cleared (rd_en is forced low while flush_i is high).
      if (flush_i) begin
        skid_cnt_q <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (skid_cnt_q == 2'd0) skid0_q <= push_ent;
            else                    skid1_q <= push_ent;
            skid_cnt_q <= skid_cnt_q + 2'd1;
          end
          2'b01: begin
            skid0_q    <= skid1_q;
            skid_cnt_q <= skid_cnt_q - 2'd1;
          end
          2'b11: begin
            if (skid_cnt_q == 2'd1) begin
              skid0_q <= push_ent;
            end else begin
              skid0_q <= skid1_q;
              skid1_q <= push_ent;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.fifo_clear_o = clear_en;
  assign bus.m_valid_o    = (skid_cnt_q != 2'd0);
  assign bus.m_data_o     = skid0_q.dat;
  assign bus.m_last_o     = (skid_cnt_q != 2'd0) && skid0_q.last;
  assign busy_o           = busy;

endmodule
